// File: rtl/mem_arbiter.sv
// Round-robin arbiter and single-access sequencer for the shared fetch/LSU
// byte-masked memory port; one access in flight, response strobed per requester.
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_req0_valid,
  input  logic [ADDR_W-1:0]     i_req0_addr,
  output logic                  o_req0_ready,
  output logic                  o_rsp0_valid,
  output logic [DATA_W-1:0]     o_rsp0_rdata,
  input  logic                  i_req1_valid,
  input  logic [ADDR_W-1:0]     i_req1_addr,
  input  logic [DATA_W-1:0]     i_req1_wdata,
  input  logic [DATA_W/8-1:0]   i_req1_mask,
  input  logic                  i_req1_wren,
  output logic                  o_req1_ready,
  output logic                  o_rsp1_valid,
  output logic [DATA_W-1:0]     o_rsp1_rdata,
  output logic [ADDR_W-1:0]     o_mem_addr,
  output logic [DATA_W-1:0]     o_mem_wdata,
  output logic [DATA_W/8-1:0]   o_mem_mask,
  output logic                  o_mem_wren,
  input  logic [DATA_W-1:0]     i_mem_rdata,
  output logic                  o_busy
);

  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned CNT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam bit          LAT0   = (MEM_LAT == 0);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] mask;
    logic              wren;
    logic              id;
  } req_t;

  state_e            state_q, state_d;
  logic              last_q, last_d;
  req_t              req_q, req_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mwren_q, mwren_d;
  logic              rsp0_v_q, rsp0_v_d, rsp1_v_q, rsp1_v_d;
  logic [DATA_W-1:0] rsp0_data_q, rsp0_data_d, rsp1_data_q, rsp1_data_d;
  logic              busy_q, busy_d;
  logic              gnt0, gnt1;
  logic              fin;
  logic [DATA_W-1:0] fin_data;

  // Grant only while idle; on a tie the requester that did not win last time goes.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (i_reset && state_q == S_IDLE) begin
      gnt0 = i_req0_valid && (!i_req1_valid || last_q);
      gnt1 = i_req1_valid && (!i_req0_valid || !last_q);
    end
  end

  assign o_req0_ready = gnt0;
  assign o_req1_ready = gnt1;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    req_d       = req_q;
    cnt_d       = cnt_q;
    mwren_d     = 1'b0;
    rsp0_v_d    = 1'b0;
    rsp1_v_d    = 1'b0;
    rsp0_data_d = rsp0_data_q;
    rsp1_data_d = rsp1_data_q;
    fin         = 1'b0;
    fin_data    = '0;
    case (state_q)
      S_IDLE: begin
        if (gnt0 || gnt1) begin
          // Fetch is always a full-word read.
          req_d.addr  = gnt1 ? i_req1_addr : i_req0_addr;
          req_d.wdata = gnt1 ? i_req1_wdata : '0;
          req_d.mask  = gnt1 ? i_req1_mask : '1;
          req_d.wren  = gnt1 && i_req1_wren;
          req_d.id    = gnt1;
          last_d      = gnt1;
          mwren_d     = gnt1 && i_req1_wren && (i_req1_mask != '0);
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (req_q.wren) begin
          fin = 1'b1;
        end else if (LAT0) begin
          fin      = 1'b1;
          fin_data = i_mem_rdata;
        end else begin
          state_d = S_WAIT;
          cnt_d   = CNT_W'(MEM_LAT - 1);
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          fin      = 1'b1;
          fin_data = i_mem_rdata;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (fin) begin
      state_d = S_IDLE;
      if (req_q.id) begin
        rsp1_v_d    = 1'b1;
        rsp1_data_d = fin_data;
      end else begin
        rsp0_v_d    = 1'b1;
        rsp0_data_d = fin_data;
      end
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      req_q       <= '0;
      cnt_q       <= '0;
      mwren_q     <= 1'b0;
      rsp0_v_q    <= 1'b0;
      rsp1_v_q    <= 1'b0;
      rsp0_data_q <= '0;
      rsp1_data_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      req_q       <= req_d;
      cnt_q       <= cnt_d;
      mwren_q     <= mwren_d;
      rsp0_v_q    <= rsp0_v_d;
      rsp1_v_q    <= rsp1_v_d;
      rsp0_data_q <= rsp0_data_d;
      rsp1_data_q <= rsp1_data_d;
      busy_q      <= busy_d;
    end
  end

  assign o_rsp0_valid = rsp0_v_q;
  assign o_rsp0_rdata = rsp0_data_q;
  assign o_rsp1_valid = rsp1_v_q;
  assign o_rsp1_rdata = rsp1_data_q;
  assign o_mem_addr   = req_q.addr;
  assign o_mem_wdata  = req_q.wdata;
  assign o_mem_mask   = req_q.mask;
  assign o_mem_wren   = mwren_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a word memory behind the port plus a transaction-level
// reference model (grant order, latency, memory contents) checked every cycle.
module tb_mem_arbiter;

  localparam int unsigned MEM_LAT = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic [10:0] a0 = '0, a1 = '0;
  logic [31:0] wd1 = '0;
  logic [3:0]  m1 = '0;
  logic        we1 = 1'b0;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_mask;
  logic        mem_wren, busy;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(11), .DATA_W(32), .MEM_LAT(MEM_LAT)) dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_req0_valid(v0), .i_req0_addr(a0), .o_req0_ready(req0_ready),
    .o_rsp0_valid(rsp0_valid), .o_rsp0_rdata(rsp0_rdata),
    .i_req1_valid(v1), .i_req1_addr(a1), .i_req1_wdata(wd1), .i_req1_mask(m1),
    .i_req1_wren(we1), .o_req1_ready(req1_ready),
    .o_rsp1_valid(rsp1_valid), .o_rsp1_rdata(rsp1_rdata),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_mask(mem_mask),
    .o_mem_wren(mem_wren), .i_mem_rdata(mem_rdata), .o_busy(busy)
  );

  // Memory behind the port: rdata follows the address by MEM_LAT cycles.
  localparam int unsigned PIPE_IX = (MEM_LAT == 0) ? 0 : MEM_LAT - 1;
  logic [31:0] ram [512] = '{0: 32'h0000_0013, default: 32'h0};
  logic [10:0] apipe [MEM_LAT+1];
  always @(posedge clk) begin
    apipe[0] <= mem_addr;
    for (int i = 1; i <= MEM_LAT; i++) apipe[i] <= apipe[i-1];
    if (mem_wren)
      for (int b = 0; b < 4; b++)
        if (mem_mask[b]) ram[mem_addr[10:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
  end
  assign mem_rdata = (MEM_LAT == 0) ? ram[mem_addr[10:2]] : ram[apipe[PIPE_IX][10:2]];

  int unsigned cyc = 0;
  int unsigned wren_cnt = 0;
  int unsigned both_rdy = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_wren) wren_cnt <= wren_cnt + 1;
  always @(negedge clk) if (req0_ready && req1_ready) both_rdy <= both_rdy + 1;

  int unsigned n_vec = 0, n_err = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model state
  typedef struct { int unsigned cyc; logic [31:0] data; } exp_t;
  logic [31:0] model_mem [512] = '{0: 32'h0000_0013, default: 32'h0};
  exp_t        q0[$], q1[$];
  bit          dut_order[$];
  bit          lg = 1'b1;
  int unsigned free_at = 0;
  bit          inflight = 1'b0;
  int unsigned iss_cyc = 0;
  logic [10:0] iss_addr;
  logic [3:0]  iss_mask;
  logic [31:0] iss_wd;
  bit          iss_wr;
  logic [31:0] last_rd0, last_rd1;

  task automatic model_reset();
    q0.delete(); q1.delete();
    lg = 1'b1; free_at = 0; inflight = 1'b0;
    v0 = 1'b0; v1 = 1'b0;
  endtask

  // One clock: predict grant, cross the edge, check responses and memory port, drive next inputs.
  task automatic step(input bit gen_rand, input bit renew);
    bit   idle, e0, e1, wr, ev0, ev1, wexp;
    exp_t e;
    #1;
    idle = (cyc >= free_at);
    e0 = idle && v0 && (!v1 || lg);
    e1 = idle && v1 && (!v0 || !lg);
    chk_eq("req0_ready", 32'(req0_ready), 32'(e0));
    chk_eq("req1_ready", 32'(req1_ready), 32'(e1));
    if (req0_ready) dut_order.push_back(1'b0);
    if (req1_ready) dut_order.push_back(1'b1);
    if (e0 || e1) begin
      wr       = e1 && we1;
      iss_addr = e1 ? a1 : a0;
      iss_mask = e1 ? m1 : 4'hF;
      iss_wd   = wd1;
      iss_wr   = wr;
      iss_cyc  = cyc + 1;
      free_at  = cyc + 2 + (wr ? 0 : MEM_LAT);
      inflight = 1'b1;
      e.cyc    = free_at;
      e.data   = wr ? 32'h0 : model_mem[iss_addr[10:2]];
      if (wr)
        for (int b = 0; b < 4; b++)
          if (iss_mask[b]) model_mem[iss_addr[10:2]][8*b +: 8] = iss_wd[8*b +: 8];
      if (e1) q1.push_back(e); else q0.push_back(e);
      lg = e1;
    end
    @(posedge clk); #1;
    ev0 = (q0.size() != 0) && (q0[0].cyc == cyc);
    ev1 = (q1.size() != 0) && (q1[0].cyc == cyc);
    chk_eq("rsp0_valid", 32'(rsp0_valid), 32'(ev0));
    chk_eq("rsp1_valid", 32'(rsp1_valid), 32'(ev1));
    if (ev0) begin e = q0.pop_front(); last_rd0 = rsp0_rdata; chk_eq("rsp0_rdata", rsp0_rdata, e.data); end
    if (ev1) begin e = q1.pop_front(); last_rd1 = rsp1_rdata; chk_eq("rsp1_rdata", rsp1_rdata, e.data); end
    wexp = inflight && (cyc == iss_cyc) && iss_wr && (iss_mask != 4'h0);
    chk_eq("mem_wren", 32'(mem_wren), 32'(wexp));
    chk_eq("busy", 32'(busy), 32'(cyc < free_at));
    if (inflight && cyc >= iss_cyc && cyc < free_at) begin
      chk_eq("mem_addr", 32'(mem_addr), 32'(iss_addr));
      chk_eq("mem_mask", 32'(mem_mask), 32'(iss_mask));
      if (iss_wr) chk_eq("mem_wdata", mem_wdata, iss_wd);
    end
    if (e0 && !renew) v0 = 1'b0;
    if (e1 && !renew) v1 = 1'b0;
    if (gen_rand) begin
      if (!v0 && $urandom_range(0, 2) == 0) begin
        v0 = 1'b1; a0 = 11'($urandom_range(0, 63));
      end
      if (!v1 && $urandom_range(0, 1) == 0) begin
        v1 = 1'b1; a1 = 11'($urandom_range(0, 63)); wd1 = $urandom;
        m1 = 4'($urandom); we1 = 1'($urandom);
      end
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    step(1'b0, 1'b0);
    while ((v0 || v1 || q0.size() != 0 || q1.size() != 0 || cyc < free_at) && n < 60) begin
      step(1'b0, 1'b0);
      n++;
    end
    chk_eq({tag, "_done"}, 32'(n < 60), 32'd1);
  endtask

  task automatic do_req1(input string tag, input logic [10:0] a, input logic [31:0] wd,
                         input logic [3:0] m, input logic we);
    int unsigned w0 = wren_cnt;
    v1 = 1'b1; a1 = a; wd1 = wd; m1 = m; we1 = we;
    drain(tag);
    chk_eq({tag, "_wren_pulses"}, wren_cnt - w0, 32'((we && m != 4'h0) ? 1 : 0));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk_eq({tag, "_rdy0"},  32'(req0_ready), 32'd0);
    chk_eq({tag, "_rdy1"},  32'(req1_ready), 32'd0);
    chk_eq({tag, "_rsp0v"}, 32'(rsp0_valid), 32'd0);
    chk_eq({tag, "_rsp0d"}, rsp0_rdata, 32'd0);
    chk_eq({tag, "_rsp1v"}, 32'(rsp1_valid), 32'd0);
    chk_eq({tag, "_rsp1d"}, rsp1_rdata, 32'd0);
    chk_eq({tag, "_maddr"}, 32'(mem_addr), 32'd0);
    chk_eq({tag, "_mwd"},   mem_wdata, 32'd0);
    chk_eq({tag, "_mmask"}, 32'(mem_mask), 32'd0);
    chk_eq({tag, "_mwren"}, 32'(mem_wren), 32'd0);
    chk_eq({tag, "_busy"},  32'(busy), 32'd0);
  endtask

  initial begin
    int base, n;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // Fetch read of word 0
    v0 = 1'b1; a0 = 11'h000;
    drain("fetch0");
    chk_eq("fetch0_value", last_rd0, 32'h0000_0013);

    do_req1("wr10", 11'd10, 32'hDEAD_BEEF, 4'b1111, 1'b1);
    chk_eq("wr10_ack", last_rd1, 32'h0);
    do_req1("rd10", 11'd10, 32'h0, 4'b1111, 1'b0);
    chk_eq("rd10_value", last_rd1, 32'hDEAD_BEEF);
    do_req1("wr20", 11'd20, 32'h1234_5678, 4'b0011, 1'b1);
    do_req1("rd20", 11'd20, 32'h0, 4'b1111, 1'b0);
    chk_eq("rd20_value", last_rd1, 32'h0000_5678);
    do_req1("wr30", 11'd30, 32'h1234_5678, 4'b0001, 1'b1);
    do_req1("rd30", 11'd30, 32'h0, 4'b1111, 1'b0);
    chk_eq("rd30_value", last_rd1, 32'h0000_0078);
    do_req1("wr40z", 11'd40, 32'hFFFF_FFFF, 4'b0000, 1'b1);
    do_req1("rd40", 11'd40, 32'h0, 4'b1111, 1'b0);
    chk_eq("rd40_value", last_rd1, 32'h0);

    // Reset in the middle of an LSU read; its response must never appear
    v1 = 1'b1; a1 = 11'd10; we1 = 1'b0; m1 = 4'hF;
    step(1'b0, 1'b0);
    if (MEM_LAT > 0) step(1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (MEM_LAT + 3) step(1'b0, 1'b0);

    // Continuous contention: grants alternate starting with fetch after reset
    base = dut_order.size();
    v0 = 1'b1; a0 = 11'd4;
    v1 = 1'b1; a1 = 11'd8; we1 = 1'b0; m1 = 4'hF;
    n = 0;
    while (dut_order.size() < base + 4 && n < 60) begin
      step(1'b0, 1'b1);
      n++;
    end
    v0 = 1'b0; v1 = 1'b0;
    chk_eq("contend_grants", 32'(dut_order.size() >= base + 4), 32'd1);
    for (int i = 0; i < 4; i++)
      if (dut_order.size() > base + i)
        chk_eq($sformatf("contend_order%0d", i), 32'(dut_order[base+i]), 32'(i % 2));
    drain("contend");

    // Randomized traffic from both requesters
    repeat (400) step(1'b1, 1'b0);
    drain("random");

    chk_eq("both_ready_cycles", both_rdy, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
